hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It decides each cycle whether the fetch unit holds its PC, whether IF/ID holds or is squashed, and whether a bubble is inserted into ID/EX. It detects load-use hazards, sequences the multi-cycle multiply/divide unit with a busy FSM, and squashes wrong-path fetches on control-flow redirects. It drives the IFU's `HazardCtr` input directly and keeps a saturating stall counter for performance debug.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/md_busy_fsm.sv | 56 +++++
 rtl/hazard_ctrl.sv | 67 ++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: mult/div FSM state encoding, register-zero
// number and the NOP word loaded by squashed pipeline registers.
package pipe_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h00000000;

endpackage

// File: rtl/md_busy_fsm.sv
// Mult/div occupancy tracker: goes BUSY on an accepted issue and stays busy
// for MD_CYCLES cycles, counted down by md_cnt.
module md_busy_fsm
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic md_accept,
  output logic md_busy
);

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  md_state_t  state, state_nxt;
  logic [7:0] md_cnt, md_cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      md_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // The last busy cycle is the one in which md_cnt has reached zero.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      MD_IDLE: begin
        if (md_accept) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt == 8'd0) begin
          state_nxt = MD_IDLE;
        end else begin
          md_cnt_nxt = md_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt  = MD_IDLE;
        md_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use and mult/div stalls,
// wrong-path squash on redirects, and a saturating stall-cycle counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wreg,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic             id_redirect,
  output logic             hazard_ctr,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic lu, mdh, stall, md_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A pending load into $0 never produces a value anyone waits for.
  assign lu = ex_mem_read && (ex_wreg != REG_ZERO) &&
              ((id_rs_used && (id_rs == ex_wreg)) ||
               (id_rt_used && (id_rt == ex_wreg)));

  assign mdh   = md_busy && (id_md_start || id_md_read);
  assign stall = lu || mdh;

  assign hazard_ctr = stall;
  assign ifid_hold  = stall;
  assign idex_flush = stall;

  // A stalled redirect stays in ID and squashes once it is allowed to move.
  assign ifid_flush = id_redirect && !stall;
  assign md_accept  = id_md_start && !stall;

  md_busy_fsm #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md_fsm (
    .clk      (clk),
    .reset    (reset),
    .md_accept(md_accept),
    .md_busy  (md_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model checked
// on every falling edge, plus literal expectations at key points.
module tb_hazard_ctrl;

  localparam int MD = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_wreg;
  logic          id_rs_used, id_rt_used, ex_mem_read;
  logic          id_md_start, id_md_read, id_redirect;
  logic          hazard_ctr, ifid_hold, ifid_flush, idex_flush, md_busy;
  logic [CW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .ex_mem_read(ex_mem_read),
    .ex_wreg    (ex_wreg),
    .id_md_start(id_md_start),
    .id_md_read (id_md_read),
    .id_redirect(id_redirect),
    .hazard_ctr (hazard_ctr),
    .ifid_hold  (ifid_hold),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index since reset, cycle of the last accepted
  // mult/div issue, and the unsaturated number of stall cycles.
  int m_cyc = 0;
  int m_issue = 0;
  bit m_issued = 1'b0;
  int m_stalls = 0;

  logic e_lu, e_busy, e_stall, e_accept, e_flush;
  int   e_cnt;

  assign e_lu = ex_mem_read && (ex_wreg != 5'd0) &&
                ((id_rs_used && id_rs == ex_wreg) || (id_rt_used && id_rt == ex_wreg));
  assign e_busy   = reset && m_issued && (m_cyc > m_issue) && (m_cyc <= m_issue + MD);
  assign e_stall  = e_lu || (e_busy && (id_md_start || id_md_read));
  assign e_accept = id_md_start && !e_stall;
  assign e_flush  = id_redirect && !e_stall;
  assign e_cnt    = (m_stalls > (2**CW - 1)) ? (2**CW - 1) : m_stalls;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc    <= 0;
      m_issued <= 1'b0;
      m_stalls <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (e_accept) begin
        m_issued <= 1'b1;
        m_issue  <= m_cyc;
      end
      if (e_stall) m_stalls <= m_stalls + 1;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_hazard_ctr", int'(hazard_ctr), int'(e_stall));
    check("m_ifid_hold",  int'(ifid_hold),  int'(e_stall));
    check("m_idex_flush", int'(idex_flush), int'(e_stall));
    check("m_ifid_flush", int'(ifid_flush), int'(e_flush));
    check("m_md_busy",    int'(md_busy),    int'(e_busy));
    check("m_stall_cnt",  int'(stall_cnt),  e_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; ex_wreg = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_mem_read = 1'b0;
    id_md_start = 1'b0; id_md_read = 1'b0; id_redirect = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] r);
    ex_mem_read = 1'b1; ex_wreg = r; id_rs = r; id_rs_used = 1'b1;
  endtask

  initial begin
    clear_in();
    reset = 1'b0;
    #2;
    check("rst_hazard", int'(hazard_ctr), 0);
    check("rst_busy",   int'(md_busy),    0);
    check("rst_cnt",    int'(stall_cnt),  0);
    do_reset();

    // Load-use on rs: one-cycle stall.
    set_lu(5'd8);
    #1;
    check("lu_hazard", int'(hazard_ctr), 1);
    check("lu_hold",   int'(ifid_hold),  1);
    check("lu_bubble", int'(idex_flush), 1);
    step();
    clear_in();
    #1;
    check("lu_clear", int'(hazard_ctr), 0);
    check("lu_cnt",   int'(stall_cnt),  1);

    // Load into $0 and unused rt never stall.
    set_lu(5'd0);
    #1;
    check("lu_r0", int'(hazard_ctr), 0);
    step();
    clear_in();
    ex_mem_read = 1'b1; ex_wreg = 5'd9; id_rt = 5'd9; id_rt_used = 1'b0;
    #1;
    check("rt_unused", int'(hazard_ctr), 0);
    step();
    clear_in();

    // Redirect alone, then redirect held under a load-use stall.
    id_redirect = 1'b1;
    #1;
    check("redir_flush",  int'(ifid_flush), 1);
    check("redir_hazard", int'(hazard_ctr), 0);
    step();
    set_lu(5'd12);
    #1;
    check("redir_lu_flush", int'(ifid_flush), 0);
    step();
    ex_mem_read = 1'b0;
    #1;
    check("redir_after", int'(ifid_flush), 1);
    step();
    clear_in();

    // Mult/div sequencing with an mfhi waiting behind it.
    do_reset();
    id_md_start = 1'b1;
    #1;
    check("md_issue_hazard", int'(hazard_ctr), 0);
    step();
    id_md_start = 1'b0;
    id_md_read  = 1'b1;
    for (int i = 1; i <= MD; i++) begin
      #1;
      check("md_busy_win", int'(md_busy),    1);
      check("md_stall",    int'(hazard_ctr), 1);
      step();
    end
    #1;
    check("md_done_busy",   int'(md_busy),    0);
    check("md_done_hazard", int'(hazard_ctr), 0);
    check("md_done_cnt",    int'(stall_cnt),  MD);
    step();
    clear_in();

    // Reset asserted in the second busy cycle.
    id_md_start = 1'b1;
    step();
    id_md_start = 1'b0;
    id_md_read  = 1'b1;
    step();
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", int'(md_busy),   0);
    check("rst_mid_cnt",  int'(stall_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_in();
    id_md_start = 1'b1;
    #1;
    check("post_rst_accept", int'(hazard_ctr), 0);
    step();
    id_md_start = 1'b0;
    #1;
    check("post_rst_busy", int'(md_busy), 1);

    // Load-use and mult/div hazard together count as one stall cycle.
    set_lu(5'd3);
    id_md_read = 1'b1;
    #1;
    check("both_hazard", int'(hazard_ctr), 1);
    step();
    check("both_cnt", int'(stall_cnt), 1);
    clear_in();
    repeat (MD + 1) step();
    check("both_idle", int'(md_busy), 0);

    // Saturation of the 4-bit counter.
    do_reset();
    set_lu(5'd20);
    repeat (20) step();
    clear_in();
    #1;
    check("sat_cnt", int'(stall_cnt), 15);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
